// File: rtl/divisor_shift_sub_pkg.sv
// Shared definitions for the shift/subtract restoring divider:
// default width, FSM state encoding and iteration-counter sizing.
package divisor_shift_sub_pkg;

    localparam int N_BITS_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Counter must hold 0..n-1; keep at least one bit for n = 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(N_BITS_DEFAULT);

endpackage

// File: rtl/divisor_shift_sub_subtrator.sv
// (N+1)-bit unsigned compare/subtract: diff_o = a_i - b_i,
// ge_o (no-borrow) is high when a_i >= b_i.
module subtrator #(
    parameter int W = 5
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         ge_o
);

    logic [W:0] wide_diff;

    // Borrow out of the extended subtraction means a_i < b_i.
    always_comb begin
        wide_diff = {1'b0, a_i} - {1'b0, b_i};
        diff_o    = wide_diff[W-1:0];
        ge_o      = ~wide_diff[W];
    end

endmodule

// File: rtl/divisor_shift_sub.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor.
// An overflow pre-check (high half >= divisor, which includes divisor 0)
// skips the iterations; otherwise N shift/compare/subtract steps build the
// quotient in the low half of the accumulator and the remainder in the high
// half. Results are held until the next accepted start.
//
// Handshake: St is a request sampled only in IDLE (Idle high); the operands
// are captured on that same edge, later St pulses and operand changes are
// ignored, and Done pulses for exactly one cycle when the results are valid.
module divisor_shift_sub
    import divisor_shift_sub_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  St,
    input  logic [2*N_BITS-1:0]   Dividendo,
    input  logic [N_BITS-1:0]     Divisor,
    output logic [N_BITS-1:0]     Quociente,
    output logic [N_BITS-1:0]     Resto,
    output logic                  V,
    output logic                  Done,
    output logic                  Idle,
    output logic [1:0]            Dbg_state
);

    localparam int CNT_W = cnt_width(N_BITS);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_BITS - 1);

    state_e              state_q, state_d;
    logic [2*N_BITS:0]   acc_q, acc_d;
    logic [N_BITS-1:0]   div_q, div_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                v_q, v_d;

    logic [2*N_BITS:0]   acc_shl;
    logic [N_BITS:0]     sub_a;
    logic [N_BITS:0]     sub_diff;
    logic                sub_ge;

    // Shifted accumulator and comparator operand: CHECK compares the
    // unshifted high half, RUN compares the shifted top N+1 bits.
    always_comb begin
        acc_shl = {acc_q[2*N_BITS-1:0], 1'b0};
        if (state_q == S_CHECK) begin
            sub_a = {1'b0, acc_q[2*N_BITS-1:N_BITS]};
        end else begin
            sub_a = acc_shl[2*N_BITS:N_BITS];
        end
    end

    subtrator #(.W(N_BITS + 1)) u_sub (
        .a_i    (sub_a),
        .b_i    ({1'b0, div_q}),
        .diff_o (sub_diff),
        .ge_o   (sub_ge)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
        end
    end

    // Next-state and datapath updates for IDLE/CHECK/RUN/DONE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE: begin
                if (St) begin
                    acc_d   = {1'b0, Dividendo};
                    div_d   = Divisor;
                    v_d     = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (sub_ge) begin
                    v_d     = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_shl;
                if (sub_ge) begin
                    acc_d[2*N_BITS:N_BITS] = sub_diff;
                    acc_d[0]               = 1'b1;
                end
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are straight decodes of the registered state and accumulator.
    always_comb begin
        Quociente = acc_q[N_BITS-1:0];
        Resto     = acc_q[2*N_BITS-1:N_BITS];
        V         = v_q;
        Done      = (state_q == S_DONE);
        Idle      = (state_q == S_IDLE);
        Dbg_state = state_q;
    end

endmodule
